// File: rtl/cpu_pkg.sv
// ============================================================================
// cpu_pkg: shared datapath widths, operand types and named register indices.
// Revision: 1.0
// ============================================================================
`default_nettype none

package cpu_pkg;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 3;

    typedef logic [ADDR_W-1:0] reg_idx_t;
    typedef logic [DATA_W-1:0] data_t;

    localparam int unsigned REG_ZERO = 0;

endpackage

`default_nettype wire

// File: rtl/reg_read_port.sv
// ============================================================================
// reg_read_port: one registered read port with zero-register, write
// forwarding and stall hold/track of the latched address.
// Revision: 1.0
// ============================================================================
`default_nettype none

module reg_read_port #(
    parameter int DATA_W   = cpu_pkg::DATA_W,
    parameter int ADDR_W   = cpu_pkg::ADDR_W,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_stall,
    input  logic [ADDR_W-1:0] i_raddr,
    input  logic [DATA_W-1:0] i_arr_data,
    input  logic              i_wr_eff,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [ADDR_W-1:0] o_addr_q,
    output logic [DATA_W-1:0] o_rdata
);

    import cpu_pkg::*;

    logic [ADDR_W-1:0] r_addr_q;
    logic [DATA_W-1:0] r_rdata;
    logic [ADDR_W-1:0] w_addr_sel;
    logic              w_is_zero;
    logic              w_fwd;
    logic [DATA_W-1:0] w_rdata_nxt;

    // While stalled the port tracks its latched register, not the live index.
    assign w_addr_sel = i_stall ? r_addr_q : i_raddr;
    assign w_is_zero  = (ZERO_REG != 0) && (w_addr_sel == ADDR_W'(REG_ZERO));
    assign w_fwd      = i_wr_eff && (i_waddr == w_addr_sel);

    always_comb begin
        w_rdata_nxt = r_rdata;
        if (!i_stall) begin
            if (w_is_zero)
                w_rdata_nxt = '0;
            else if (w_fwd)
                w_rdata_nxt = i_wdata;
            else
                w_rdata_nxt = i_arr_data;
        end else if (w_fwd) begin
            w_rdata_nxt = i_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr_q <= '0;
            r_rdata  <= '0;
        end else begin
            r_addr_q <= w_addr_sel;
            r_rdata  <= w_rdata_nxt;
        end
    end

    assign o_addr_q = r_addr_q;
    assign o_rdata  = r_rdata;

endmodule

`default_nettype wire

// File: rtl/reg_file8x8.sv
// ============================================================================
// reg_file8x8: 8x8 register file, one write port and two registered read
// ports with same-edge forwarding and stall hold.
// Revision: 1.0
// ============================================================================
`default_nettype none

module reg_file8x8 #(
    parameter int DATA_W   = cpu_pkg::DATA_W,
    parameter int ADDR_W   = cpu_pkg::ADDR_W,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr_a,
    input  logic [ADDR_W-1:0] raddr_b,
    input  logic              stall,
    output logic [DATA_W-1:0] rdata_a,
    output logic [DATA_W-1:0] rdata_b
);

    import cpu_pkg::*;

    localparam int NREGS = 1 << ADDR_W;

    logic [DATA_W-1:0] r_regs [NREGS];
    logic              w_wr_eff;
    logic [ADDR_W-1:0] w_addr_q_a;
    logic [ADDR_W-1:0] w_addr_q_b;
    logic [DATA_W-1:0] w_arr_a;
    logic [DATA_W-1:0] w_arr_b;

    assign w_wr_eff = we && !((ZERO_REG != 0) && (waddr == ADDR_W'(REG_ZERO)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++)
                r_regs[i] <= '0;
        end else if (w_wr_eff) begin
            r_regs[waddr] <= wdata;
        end
    end

    // Array reads see pre-edge contents; the ports forward same-edge writes.
    assign w_arr_a = r_regs[raddr_a];
    assign w_arr_b = r_regs[raddr_b];

    reg_read_port #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG)
    ) u_port_a (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_stall    (stall),
        .i_raddr    (raddr_a),
        .i_arr_data (w_arr_a),
        .i_wr_eff   (w_wr_eff),
        .i_waddr    (waddr),
        .i_wdata    (wdata),
        .o_addr_q   (w_addr_q_a),
        .o_rdata    (rdata_a)
    );

    reg_read_port #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG)
    ) u_port_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_stall    (stall),
        .i_raddr    (raddr_b),
        .i_arr_data (w_arr_b),
        .i_wr_eff   (w_wr_eff),
        .i_waddr    (waddr),
        .i_wdata    (wdata),
        .o_addr_q   (w_addr_q_b),
        .o_rdata    (rdata_b)
    );

    // The latched addresses are kept inside the ports; nothing here needs them.
    logic w_unused;
    assign w_unused = ^{w_addr_q_a, w_addr_q_b};

endmodule

`default_nettype wire
